pixel_sequencer: RTL and testbench
==================================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 Parameter pixel_count SHALL default to 4 and set the number of pixels read per frame (>=2).
REQ-002 Parameter erase_cycles SHALL default to 5 and set the ERASE phase length in cycles (>=1).
REQ-003 Parameter convert_cycles SHALL default to 256 and set the CONVERT phase length in cycles (>=1).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-006 Port start, input, 1 bit, SHALL be the frame-start request, sampled only in IDLE.
REQ-007 Port expose_cycles, input, 16 bits, SHALL be the exposure length, latched on accepted start.
REQ-008 Port read_ready, input, 1 bit, SHALL be the downstream acceptance of the current pixel during READ.
REQ-009 Ports erase, expose, convert, read, output, 1 bit each, SHALL be the pixel-array phase controls.
REQ-010 Port pixel_select, output, $clog2(pixel_count) bits, SHALL be the index of the pixel being read.
REQ-011 Port busy, output, 1 bit, SHALL be high while a frame is in progress.
REQ-012 Port frame_done, output, 1 bit, SHALL be a one-cycle completion pulse.

Function
REQ-013 States SHALL be IDLE, ERASE, EXPOSE, CONVERT, READ; all outputs registered.
REQ-014 IDLE: all phase controls 0, pixel_select 0, busy 0.
REQ-015 start=1 at an edge in IDLE SHALL enter ERASE on that edge; expose_cycles latched on the same edge.
REQ-016 ERASE SHALL last exactly erase_cycles cycles with erase=1, then enter EXPOSE.
REQ-017 EXPOSE SHALL last exactly the latched expose_cycles cycles with expose=1; latched value 0 SHALL be treated as 1.
REQ-018 CONVERT SHALL last exactly convert_cycles cycles with convert=1, then enter READ.
REQ-019 READ: read=1 continuously; pixel transferred in each cycle with read_ready=1; pixel_select increments after each transfer; holds while read_ready=0.
REQ-020 Transfer of pixel pixel_count-1 SHALL return to IDLE; frame_done=1 in the first IDLE cycle only.
REQ-021 Exactly one phase control SHALL be high in any cycle; busy=1 in every non-IDLE state.
REQ-022 start while busy SHALL be ignored (no queuing); start held high SHALL begin a new frame after exactly one IDLE cycle.
REQ-023 expose_cycles changes after latching SHALL not affect the current frame.
REQ-024 Phase counters SHALL count down from length-1 to 0; no wrap or overrun of pixel_select past pixel_count-1.

Reset
REQ-025 reset=1 SHALL, at the next edge and in any state, force IDLE, all outputs 0, counters 0, latched exposure 0.
REQ-026 reset SHALL take priority over start; a frame aborted by reset SHALL not produce frame_done.

Structure
REQ-027 Package pixel_pkg SHALL hold the state enum typedef and default constants for erase_cycles/convert_cycles.
REQ-028 Sub-module phase_counter (16-bit loadable down-counter, zero flag) SHALL be instantiated once and shared by all timed phases.
REQ-029 pixel_sequencer outputs SHALL connect directly to the pixel array controls and pixel_select.

Verification (pixel_count=4, erase_cycles=5, convert_cycles=8)
REQ-030 start at cycle 0, expose_cycles=10, read_ready=1 -> erase cycles 1-5, expose 6-15, convert 16-23, read 24-27 with pixel_select 0,1,2,3, frame_done at 28 only, busy 1-27.
REQ-031 As REQ-030 but read_ready=0 for 3 cycles while pixel_select=2 -> pixel_select holds 2 for 4 cycles, frame_done at 31.
REQ-032 expose_cycles=0 -> expose high exactly 1 cycle, convert starts cycle 7.
REQ-033 start held high throughout; expose_cycles changed to 3 at cycle 8 -> first frame unchanged, second frame erase starts cycle 29 with exposure 3.
REQ-034 reset at cycle 10 (EXPOSE) -> cycle 11 all outputs 0, busy 0, no frame_done; new start accepted afterward.
REQ-035 Every cycle of every test -> at most one phase control high, pixel_select < pixel_count.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel-array sequencer: the FSM state
// encoding, default phase lengths and the phase-counter load helper.
package pixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    localparam int CNT_W                  = 16;
    localparam int PIXEL_COUNT_DEFAULT    = 4;
    localparam int ERASE_CYCLES_DEFAULT   = 5;
    localparam int CONVERT_CYCLES_DEFAULT = 256;

    // A phase of length N runs the counter N-1 .. 0; a zero length behaves as one cycle.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter shared by all timed phases; zero marks the last
// cycle of the phase currently being timed.
module phase_counter
    import pixel_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pixel_sequencer.sv
// Pixel-array frame sequencer: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> IDLE,
// with every output registered so it changes on the same edge as the state.
module pixel_sequencer
    import pixel_pkg::*;
#(
    parameter int pixel_count    = PIXEL_COUNT_DEFAULT,
    parameter int erase_cycles   = ERASE_CYCLES_DEFAULT,
    parameter int convert_cycles = CONVERT_CYCLES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [15:0]                    expose_cycles,
    input  logic                           read_ready,
    output logic                           erase,
    output logic                           expose,
    output logic                           convert,
    output logic                           read,
    output logic [$clog2(pixel_count)-1:0] pixel_select,
    output logic                           busy,
    output logic                           frame_done,
    output state_t                         state
);

    localparam int SEL_W = $clog2(pixel_count);
    localparam logic [SEL_W-1:0] LAST_PIXEL = SEL_W'(pixel_count - 1);

    state_t           next_state;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             sel_inc;
    logic             sel_clr;
    logic             done_next;
    logic             expose_load;
    logic [15:0]      expose_q;

    phase_counter u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // READ handshake: read stays high for the whole phase; a pixel is
    // transferred in every cycle where read_ready is high, and pixel_select
    // holds its value across cycles where read_ready is low.
    always_comb begin
        next_state  = state;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        cnt_dec     = 1'b0;
        sel_inc     = 1'b0;
        sel_clr     = 1'b0;
        done_next   = 1'b0;
        expose_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state  = ST_ERASE;
                    cnt_load    = 1'b1;
                    cnt_value   = phase_load(CNT_W'(erase_cycles));
                    expose_load = 1'b1;
                end
            end
            ST_ERASE: begin
                if (cnt_zero) begin
                    next_state = ST_EXPOSE;
                    cnt_load   = 1'b1;
                    cnt_value  = phase_load(expose_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_EXPOSE: begin
                if (cnt_zero) begin
                    next_state = ST_CONVERT;
                    cnt_load   = 1'b1;
                    cnt_value  = phase_load(CNT_W'(convert_cycles));
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CONVERT: begin
                if (cnt_zero) begin
                    next_state = ST_READ;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_READ: begin
                if (read_ready) begin
                    if (pixel_select == LAST_PIXEL) begin
                        next_state = ST_IDLE;
                        sel_clr    = 1'b1;
                        done_next  = 1'b1;
                    end else begin
                        sel_inc = 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                sel_clr    = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            erase        <= 1'b0;
            expose       <= 1'b0;
            convert      <= 1'b0;
            read         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            pixel_select <= '0;
            expose_q     <= '0;
        end else begin
            state      <= next_state;
            erase      <= (next_state == ST_ERASE);
            expose     <= (next_state == ST_EXPOSE);
            convert    <= (next_state == ST_CONVERT);
            read       <= (next_state == ST_READ);
            busy       <= (next_state != ST_IDLE);
            frame_done <= done_next;
            if (expose_load) begin
                expose_q <= expose_cycles;
            end
            if (sel_clr) begin
                pixel_select <= '0;
            end else if (sel_inc) begin
                pixel_select <= pixel_select + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0({erase, expose, convert, read}));
            assert (pixel_select <= LAST_PIXEL);
            assert (busy == (state != ST_IDLE));
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: directed timelines checked against
// constant vector tables, plus random traffic checked against a phase-plan model.
module tb_pixel_sequencer;
    import pixel_pkg::*;

    localparam int PC  = 4;
    localparam int EC  = 5;
    localparam int CC  = 8;
    localparam int CAP = 64;

    // Control field order: {erase, expose, convert, read, busy, frame_done}
    localparam logic [5:0] C_ID = 6'b000000;
    localparam logic [5:0] C_ER = 6'b100010;
    localparam logic [5:0] C_EX = 6'b010010;
    localparam logic [5:0] C_CV = 6'b001010;
    localparam logic [5:0] C_RD = 6'b000110;
    localparam logic [5:0] C_DN = 6'b000001;

    typedef struct {
        int         lo;
        int         hi;
        logic [5:0] ctl;
        logic [1:0] sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] expose_cycles;
    logic        read_ready;
    logic        erase, expose, convert, read, busy, frame_done;
    logic [1:0]  pixel_select;
    state_t      dut_state;

    int n_cmp = 0;
    int n_err = 0;
    int scen_cyc;
    logic [7:0] cap [0:CAP-1];
    vec_t vec_q[$];

    // Reference model: a frame is a plan of timed phase cycles, then a pixel walk.
    int   plan_q[$];
    bit   m_reading;
    int   m_pix;
    bit   m_done;

    pixel_sequencer #(
        .pixel_count    (PC),
        .erase_cycles   (EC),
        .convert_cycles (CC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .expose_cycles (expose_cycles),
        .read_ready    (read_ready),
        .erase         (erase),
        .expose        (expose),
        .convert       (convert),
        .read          (read),
        .pixel_select  (pixel_select),
        .busy          (busy),
        .frame_done    (frame_done),
        .state         (dut_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_out();
        logic [5:0] ctl;
        logic [1:0] sel;
        ctl = C_ID;
        sel = 2'd0;
        if (plan_q.size() > 0) begin
            case (plan_q[0])
                1:       ctl = C_ER;
                2:       ctl = C_EX;
                default: ctl = C_CV;
            endcase
        end else if (m_reading) begin
            ctl = C_RD;
            sel = 2'(m_pix);
        end else if (m_done) begin
            ctl = C_DN;
        end
        return {ctl, sel};
    endfunction

    task automatic model_step(input logic s, input logic [15:0] e, input logic r, input logic rs);
        int ex_len;
        if (rs) begin
            plan_q.delete();
            m_reading = 1'b0;
            m_pix     = 0;
            m_done    = 1'b0;
        end else if (plan_q.size() > 0) begin
            void'(plan_q.pop_front());
            if (plan_q.size() == 0) begin
                m_reading = 1'b1;
                m_pix     = 0;
            end
        end else if (m_reading) begin
            if (r) begin
                if (m_pix == PC - 1) begin
                    m_reading = 1'b0;
                    m_pix     = 0;
                    m_done    = 1'b1;
                end else begin
                    m_pix++;
                end
            end
        end else begin
            m_done = 1'b0;
            if (s) begin
                ex_len = (e == 16'd0) ? 1 : int'(e);
                for (int i = 0; i < EC; i++) plan_q.push_back(1);
                for (int i = 0; i < ex_len; i++) plan_q.push_back(2);
                for (int i = 0; i < CC; i++) plan_q.push_back(3);
            end
        end
    endtask

    task automatic run_cycle(input logic s, input logic [15:0] e, input logic r, input logic rs);
        logic [7:0] act;
        logic [7:0] exp_v;
        start         = s;
        expose_cycles = e;
        read_ready    = r;
        reset         = rs;
        @(negedge clk);
        act = {erase, expose, convert, read, busy, frame_done, pixel_select};
        if (scen_cyc < CAP) cap[scen_cyc] = act;
        exp_v = model_out();
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL model cyc %0d: got %b want %b", scen_cyc, act, exp_v);
        end
        n_cmp++;
        if ($countones({erase, expose, convert, read}) > 1) begin
            n_err++;
            $display("FAIL onehot cyc %0d: got %b want at most one phase high",
                     scen_cyc, {erase, expose, convert, read});
        end
        @(posedge clk);
        model_step(s, e, r, rs);
        #1;
        scen_cyc++;
    endtask

    task automatic begin_scenario();
        run_cycle(1'b0, 16'd0, 1'b1, 1'b1);
        vec_q.delete();
        scen_cyc = 0;
        for (int i = 0; i < CAP; i++) cap[i] = 8'hxx;
    endtask

    task automatic add_vec(input int lo, input int hi, input logic [5:0] ctl, input logic [1:0] sel);
        vec_t v;
        v.lo  = lo;
        v.hi  = hi;
        v.ctl = ctl;
        v.sel = sel;
        vec_q.push_back(v);
    endtask

    task automatic check_vectors(input string name);
        logic [7:0] exp_v;
        foreach (vec_q[k]) begin
            for (int c = vec_q[k].lo; c <= vec_q[k].hi; c++) begin
                exp_v = {vec_q[k].ctl, vec_q[k].sel};
                n_cmp++;
                if (cap[c] !== exp_v) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got %b want %b", name, c, cap[c], exp_v);
                end
            end
        end
    endtask

    task automatic add_read(input int first);
        for (int p = 0; p < PC; p++) add_vec(first + p, first + p, C_RD, 2'(p));
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        expose_cycles = 16'd0;
        read_ready    = 1'b0;
        plan_q.delete();
        m_reading = 1'b0;
        m_pix     = 0;
        m_done    = 1'b0;
        scen_cyc  = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        n_cmp++;
        if ({erase, expose, convert, read, busy, frame_done, pixel_select} !== 8'd0 ||
            dut_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %b state %0d want 0 state 0",
                     {erase, expose, convert, read, busy, frame_done, pixel_select}, dut_state);
        end
        @(posedge clk);
        #1;

        // Basic frame, exposure 10, downstream always ready
        begin_scenario();
        for (int c = 0; c < 32; c++) run_cycle(c == 0, 16'd10, 1'b1, 1'b0);
        add_vec(0, 0, C_ID, 0);
        add_vec(1, 5, C_ER, 0);
        add_vec(6, 15, C_EX, 0);
        add_vec(16, 23, C_CV, 0);
        add_read(24);
        add_vec(28, 28, C_DN, 0);
        add_vec(29, 31, C_ID, 0);
        check_vectors("basic");

        // Downstream stall for three cycles on pixel 2
        begin_scenario();
        for (int c = 0; c < 33; c++) run_cycle(c == 0, 16'd10, !(c >= 26 && c <= 28), 1'b0);
        add_vec(0, 0, C_ID, 0);
        add_vec(1, 5, C_ER, 0);
        add_vec(6, 15, C_EX, 0);
        add_vec(16, 23, C_CV, 0);
        add_vec(24, 24, C_RD, 0);
        add_vec(25, 25, C_RD, 1);
        add_vec(26, 29, C_RD, 2);
        add_vec(30, 30, C_RD, 3);
        add_vec(31, 31, C_DN, 0);
        add_vec(32, 32, C_ID, 0);
        check_vectors("stall");

        // Zero exposure behaves as one cycle
        begin_scenario();
        for (int c = 0; c < 22; c++) run_cycle(c == 0, 16'd0, 1'b1, 1'b0);
        add_vec(0, 0, C_ID, 0);
        add_vec(1, 5, C_ER, 0);
        add_vec(6, 6, C_EX, 0);
        add_vec(7, 14, C_CV, 0);
        add_read(15);
        add_vec(19, 19, C_DN, 0);
        add_vec(20, 21, C_ID, 0);
        check_vectors("expose0");

        // Start held high, exposure input changed mid-frame
        begin_scenario();
        for (int c = 0; c < 55; c++) run_cycle(1'b1, (c < 8) ? 16'd10 : 16'd3, 1'b1, 1'b0);
        add_vec(0, 0, C_ID, 0);
        add_vec(1, 5, C_ER, 0);
        add_vec(6, 15, C_EX, 0);
        add_vec(16, 23, C_CV, 0);
        add_read(24);
        add_vec(28, 28, C_DN, 0);
        add_vec(29, 33, C_ER, 0);
        add_vec(34, 36, C_EX, 0);
        add_vec(37, 44, C_CV, 0);
        add_read(45);
        add_vec(49, 49, C_DN, 0);
        add_vec(50, 54, C_ER, 0);
        check_vectors("held_start");

        // Reset during EXPOSE, then a fresh frame
        begin_scenario();
        for (int c = 0; c < 42; c++) run_cycle(c == 0 || c == 12, 16'd10, 1'b1, c == 10);
        add_vec(0, 0, C_ID, 0);
        add_vec(1, 5, C_ER, 0);
        add_vec(6, 10, C_EX, 0);
        add_vec(11, 12, C_ID, 0);
        add_vec(13, 17, C_ER, 0);
        add_vec(18, 27, C_EX, 0);
        add_vec(28, 35, C_CV, 0);
        add_read(36);
        add_vec(40, 40, C_DN, 0);
        add_vec(41, 41, C_ID, 0);
        check_vectors("abort");

        // Random traffic against the model
        begin_scenario();
        for (int c = 0; c < 3000; c++) begin
            run_cycle($urandom_range(0, 3) == 0,
                      16'($urandom_range(0, 12)),
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
